uart_rx_buffered: RTL
=====================

Name: uart_rx_buffered

Overview:
- Parametrised successor to the existing UART receiver, for the PMOD USB-serial link on the 12 MHz board clock.
- Oversampling RX with majority-vote bit decisions.
- Configurable data bits, parity mode and stop bits.
- Internal receive FIFO with valid/ready output, hardware flow control (RTS#) driven from FIFO fill level, and per-byte plus sticky error reporting.
- Sits between the PMOD RXD pin and consumers such as the LED driver or RAM loader.

Parameters:
CLK_HZ, 12000000, input clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 8, sample ticks per bit; even, >=4
DATA_BITS, 8, payload bits per frame; 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, entries; power of two, >=4
RTS_MARGIN, 4, free entries left when RTS# deasserts

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
rts_n  out  1  active-low request-to-send to the host
m_data  out  DATA_BITS  FIFO head byte
m_perr  out  1  parity-error flag stored with the head byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts head when m_valid & m_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: any parity mismatch
overrun  out  1  sticky: byte dropped because FIFO full
err_clr  in  1  one-cycle pulse clears all sticky flags

Behaviour:
- Reset (async assert, sync release): all outputs 0 except rts_n = 1; FIFO empty; FSM in IDLE; synchroniser flops preset to 1. rts_n drops to 0 on the first clock after release.
- rx passes through a 2-flop synchroniser before any use.
- Tick generator: DIV = round(CLK_HZ / (BAUD*OVERSAMPLE)), computed at elaboration; defaults give DIV = 13. Counter restarts on start-edge detection so sampling is phase-aligned.
- Bit value = majority of samples at ticks OS/2-1, OS/2, OS/2+1 within each bit.
- FSM states:
  - IDLE: a 1->0 edge on synced rx -> START.
  - START: majority at mid-bit must be 0, else back to IDLE (glitch rejected, nothing reported).
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: only when PARITY != 0; compare against the computed odd/even parity.
  - STOP: STOP_BITS bits, each checked at mid-bit.
  - PUSH: one cycle, then IDLE.
  - BREAK: wait for synced rx = 1, then IDLE.
- Stop bit 0: byte discarded, frame_err set, FSM -> BREAK.
- Parity mismatch: byte still pushed with m_perr = 1, parity_err set.
- Push happens in the PUSH cycle, i.e. after the first stop bit's mid-sample; a second stop bit is still checked before IDLE. m_valid rises the cycle after the push (first-word fall-through, registered head).
- Push while full: byte dropped, overrun set. Push and pop in the same cycle while full: both succeed, count unchanged.
- Pop while empty: ignored.
- rts_n = 1 when fifo_count >= FIFO_DEPTH - RTS_MARGIN, else 0. Registered, one cycle after the count change.
- Sticky set and err_clr in the same cycle: set wins.
- Reset mid-frame: the frame is abandoned and the FIFO is flushed. Bench releases reset only with rx high.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - rx FSM state enum;
  - divisor function calc_div(clk_hz, baud, os).
- Sub-module sync_fifo (parametrised WIDTH/DEPTH, FWFT, count output). Stores {perr, data} at WIDTH = DATA_BITS+1.
- Synchroniser, tick generator and FSM stay in uart_rx_buffered.

Test Plan:
1. Defaults, send 8N1 0xA5 with m_ready=1 -> m_valid pulse with m_data=0xA5, m_perr=0, all sticky flags 0, fifo_count returns to 0.
2. rx low for 3 ticks (39 clocks), then high -> no push, no flags, FSM returns to IDLE; a following 0x3C frame is received correctly.
3. PARITY=2, send 0x37 with parity bit 0 (correct is 1) -> byte 0x37 queued with m_perr=1, parity_err=1; err_clr pulse -> parity_err=0.
4. Send 0x55 with stop bit 0, hold rx low 2 bit-times, then idle -> no push, frame_err=1; next 0x81 is received with no new errors.
5. m_ready=0, send bytes 0x00..0x10 (17 bytes):
   - rts_n rises one cycle after fifo_count reaches 12;
   - 17th byte dropped, overrun=1, fifo_count=16;
   - then m_ready=1 -> drains 0x00..0x0F in order, rts_n returns to 0 below 12.
6. Assert reset_n low during data bit 3 of a frame -> outputs at reset values immediately; release with rx high, send 0xF0 -> received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the buffered UART receiver.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_PUSH,
      ST_BREAK
   } rx_state_t;

   // Rounded clock divider for one oversample tick.
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      int den;
      den = baud * os;
      return (clk_hz + den / 2) / den;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and occupancy count.
// A write while full is accepted only when a read frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_wr, do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_rd    = rd_en && !empty;
      do_wr    = wr_en && (!full || rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_wr && !do_rd) begin
         count_d = count_q + 1'b1;
      end else if (!do_wr && do_rd) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with majority-vote bits, receive FIFO, RTS# flow control
// and sticky line-error flags.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a 1->0 edge on synced rx
// ST_START  | verifying start bit at mid-bit, glitches drop back to idle
// ST_DATA   | shifting in DATA_BITS, LSB first
// ST_PARITY | sampling parity bit and comparing with computed parity
// ST_STOP   | checking a stop bit at mid-bit
// ST_PUSH   | one-cycle write of {perr, data} into the FIFO
// ST_BREAK  | bad stop bit, waiting for the line to return high
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 8,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int RTS_MARGIN = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          rx,
   output logic                          rts_n,
   output logic [DATA_BITS-1:0]          m_data,
   output logic                          m_perr,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   input  logic                          err_clr
);

   localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  OS_RELOAD  = OS_W'(OVERSAMPLE - 1);
   // os_q counts down, so the three vote samples sit at OS/2, OS/2-1 and OS/2-2
   localparam logic [OS_W-1:0]  SAMP_A     = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0]  SAMP_B     = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  SAMP_MID   = OS_W'(OVERSAMPLE / 2 - 2);
   localparam logic [BIT_W-1:0] BIT_RELOAD = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] RTS_LEVEL  = CNT_W'(FIFO_DEPTH - RTS_MARGIN);

   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t            state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [OS_W-1:0]      os_q, os_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_q, perr_d;
   logic                 stop2_q, stop2_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;
   logic                 rts_n_q, rts_n_d;

   logic                 tick, mid, bit_end, maj, exp_par;
   logic                 push, frame_set;
   logic                 fifo_empty, fifo_full;
   logic [DATA_BITS:0]   fifo_rd_data;
   logic [CNT_W-1:0]     fifo_cnt;

   sync_fifo #(
      .WIDTH (DATA_BITS + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (push),
      .wr_data ({perr_q, shreg_q}),
      .rd_en   (m_ready),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_cnt)
   );

   assign m_data     = fifo_rd_data[DATA_BITS-1:0];
   assign m_perr     = fifo_rd_data[DATA_BITS];
   assign m_valid    = !fifo_empty;
   assign fifo_count = fifo_cnt;
   assign rts_n      = rts_n_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;

   always_comb begin
      tick      = (state_q != ST_IDLE) && (state_q != ST_BREAK) && (div_q == '0);
      mid       = tick && (os_q == SAMP_MID);
      bit_end   = tick && (os_q == '0);
      maj       = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync_q) | (samp_q[0] & rx_sync_q);
      exp_par   = (PARITY == PAR_ODD) ? ~^shreg_q : ^shreg_q;

      state_d   = state_q;
      div_d     = div_q;
      os_d      = os_q;
      bit_d     = bit_q;
      samp_d    = samp_q;
      shreg_d   = shreg_q;
      perr_d    = perr_q;
      stop2_d   = stop2_q;
      push      = 1'b0;
      frame_set = 1'b0;

      if (tick) begin
         div_d = DIV_RELOAD;
         os_d  = (os_q == '0) ? OS_RELOAD : os_q - 1'b1;
         if (os_q == SAMP_A || os_q == SAMP_B) begin
            samp_d = {samp_q[0], rx_sync_q};
         end
      end else if (div_q != '0) begin
         div_d = div_q - 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               state_d = ST_START;
               div_d   = DIV_RELOAD;
               os_d    = OS_RELOAD;
               perr_d  = 1'b0;
               stop2_d = 1'b0;
            end
         end
         ST_START: begin
            if (mid && maj) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = BIT_RELOAD;
            end
         end
         ST_DATA: begin
            if (mid) begin
               shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
            end
            if (bit_end) begin
               if (bit_q == '0) begin
                  state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q - 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (mid) begin
               perr_d = (maj != exp_par);
            end
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (mid) begin
               if (!maj) begin
                  frame_set = 1'b1;
                  state_d   = ST_BREAK;
               end else if (stop2_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_PUSH;
               end
            end
         end
         ST_PUSH: begin
            push = 1'b1;
            // the tick counter keeps running, so a second stop bit is still checked
            if (STOP_BITS == 2) begin
               state_d = ST_STOP;
               stop2_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BREAK: begin
            if (rx_sync_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      frame_err_d  = err_clr ? 1'b0 : frame_err_q;
      parity_err_d = err_clr ? 1'b0 : parity_err_q;
      overrun_d    = err_clr ? 1'b0 : overrun_q;
      if (frame_set) frame_err_d = 1'b1;
      if (push && perr_q) parity_err_d = 1'b1;
      if (push && fifo_full && !m_ready) overrun_d = 1'b1;

      rts_n_d = (fifo_cnt >= RTS_LEVEL);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= ST_IDLE;
         div_q        <= '0;
         os_q         <= '0;
         bit_q        <= '0;
         samp_q       <= '0;
         shreg_q      <= '0;
         perr_q       <= 1'b0;
         stop2_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
         rts_n_q      <= 1'b1;
      end else begin
         rx_meta_q    <= rx;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         state_q      <= state_d;
         div_q        <= div_d;
         os_q         <= os_d;
         bit_q        <= bit_d;
         samp_q       <= samp_d;
         shreg_q      <= shreg_d;
         perr_q       <= perr_d;
         stop2_q      <= stop2_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
         rts_n_q      <= rts_n_d;
      end
   end

endmodule
